// File: rtl/regfile_sb_pkg.sv
// Shared constants for the register file with integrated scoreboard.
// Widths and register counts cover the RV32E and RV32I configurations.
package regfile_sb_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_E   = 16;
  localparam int NREG_I   = 32;
  localparam int X0       = 0;

endpackage

// File: rtl/regfile_sb_popcount.sv
// Population count of an N-bit vector; feeds the registered busy counter.
module sb_popcount #(
  parameter int N  = 16,
  parameter int CW = $clog2(N) + 1
) (
  input  logic [N-1:0]  bits_i,
  output logic [CW-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < N; i++) begin
      count_o = count_o + CW'(bits_i[i]);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Flop-based register file with write-through bypass and a per-register
// busy scoreboard for issue-stage hazard detection.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_E,
  parameter int NRD  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  input  logic                flush,
  output logic [AW:0]         busy_cnt
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [AW:0]     busy_cnt_q;
  logic [AW:0]     busy_cnt_d;
  logic [AW-1:0]   rd_addr [NRD];
  logic            wr_x;
  logic            alloc_x;

  assign wr_x    = wr_en    && (wr_addr    != AW'(X0));
  assign alloc_x = alloc_en && (alloc_addr != AW'(X0));

  // Write clears the reservation first so a same-edge alloc re-reserves;
  // flush overrides both. x0 can never hold a reservation.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_x) begin
      regs_d[wr_addr] = wr_data;
      busy_d[wr_addr] = 1'b0;
    end
    if (alloc_x) begin
      busy_d[alloc_addr] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  sb_popcount #(
    .N  (NREG),
    .CW (AW + 1)
  ) u_popcount (
    .bits_i  (busy_d),
    .count_o (busy_cnt_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      rd_addr[k] = rs_addr[k*AW +: AW];
    end
  end

  // Outputs are gated by rst so the bypass path cannot leak data during reset.
  always_comb begin
    rs_data = '0;
    rs_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      if (!rst && (rd_addr[k] != AW'(X0))) begin
        if (wr_x && (wr_addr == rd_addr[k])) begin
          rs_data[k*XLEN +: XLEN] = wr_data;
        end else begin
          rs_data[k*XLEN +: XLEN] = regs_q[rd_addr[k]];
        end
        if (wr_x && (wr_addr == rd_addr[k]) &&
            !(alloc_x && (alloc_addr == rd_addr[k]))) begin
          rs_busy[k] = 1'b0;
        end else begin
          rs_busy[k] = busy_q[rd_addr[k]];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table, random traffic
// against an array-based reference model, and asynchronous reset sequences.
module tb_regfile_sb;
  import regfile_sb_pkg::*;

  localparam int XLEN = XLEN_DEF;
  localparam int NREG = NREG_E;
  localparam int NRD  = 2;
  localparam int AW   = $clog2(NREG);
  localparam int CW   = AW + 1;

  logic                clk;
  logic                rst;
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      rs_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                alloc_en;
  logic [AW-1:0]       alloc_addr;
  logic                flush;
  logic [AW:0]         busy_cnt;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk        (clk),
    .rst        (rst),
    .rs_addr    (rs_addr),
    .rs_data    (rs_data),
    .rs_busy    (rs_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush),
    .busy_cnt   (busy_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [XLEN-1:0] m_regs [NREG];
  bit              m_busy [NREG];
  logic [CW-1:0]   exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < NREG; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic logic [XLEN-1:0] model_rd(int a);
    if (rst || a == 0) return '0;
    if (wr_en && int'(wr_addr) == a) return wr_data;
    return m_regs[a];
  endfunction

  function automatic logic model_rbusy(int a);
    if (rst || a == 0) return 1'b0;
    if (wr_en && int'(wr_addr) == a && !(alloc_en && int'(alloc_addr) == a)) return 1'b0;
    return m_busy[a];
  endfunction

  // Architectural effect of one clock edge, from the current inputs.
  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      if (wr_en && wr_addr != 0) begin
        m_regs[wr_addr] = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
      if (flush) begin
        for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_ports(string tag);
    for (int k = 0; k < NRD; k++) begin
      int a;
      a = int'(rs_addr[k*AW +: AW]);
      check($sformatf("%s data p%0d x%0d", tag, k, a), 64'(rs_data[k*XLEN +: XLEN]), 64'(model_rd(a)));
      check($sformatf("%s busy p%0d x%0d", tag, k, a), 64'(rs_busy[k]), 64'(model_rbusy(a)));
    end
  endtask

  // Advance one edge, update the model, then compare the registered count.
  task automatic clock_edge(string tag);
    @(posedge clk);
    model_edge();
    exp_q.push_back(CW'(model_count()));
    #1;
    check({tag, " busy_cnt"}, 64'(busy_cnt), 64'(exp_q.pop_front()));
  endtask

  // ---------------- drivers ----------------
  task automatic drive_idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
  endtask

  task automatic set_rd(int k, int a);
    rs_addr[k*AW +: AW] = AW'(a);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic            we;
    int              wa;
    logic [XLEN-1:0] wd;
    logic            ae;
    int              aa;
    logic            fl;
    int              ra;
    logic [XLEN-1:0] exp_data;
    logic            exp_busy;
    int              exp_cnt;
  } vec_t;

  vec_t vt [20];
  int   nvec;

  task automatic add_vec(logic we, int wa, logic [XLEN-1:0] wd, logic ae, int aa,
                         logic fl, int ra, logic [XLEN-1:0] ed, logic eb, int ec);
    vt[nvec] = '{we, wa, wd, ae, aa, fl, ra, ed, eb, ec};
    nvec++;
  endtask

  initial begin
    rst = 1'b1;
    rs_addr = '0;
    drive_idle();
    model_reset();
    nvec = 0;

    //      we  wa  wd            ae  aa fl ra exp_data      eb ec
    add_vec(1,  5, 32'hDEADBEEF, 0,  0, 0, 5, 32'hDEADBEEF, 0, 0); // bypass
    add_vec(0,  0, 32'h0,        0,  0, 0, 5, 32'hDEADBEEF, 0, 0); // stored
    add_vec(1,  0, 32'h1234,     0,  0, 0, 0, 32'h0,        0, 0); // x0 write
    add_vec(0,  0, 32'h0,        0,  0, 0, 0, 32'h0,        0, 0);
    add_vec(0,  0, 32'h0,        1,  3, 0, 3, 32'h0,        0, 1); // alloc x3
    add_vec(0,  0, 32'h0,        0,  0, 0, 3, 32'h0,        1, 1);
    add_vec(1,  3, 32'h7,        0,  0, 0, 3, 32'h7,        0, 0); // wb clears
    add_vec(0,  0, 32'h0,        0,  0, 0, 3, 32'h7,        0, 0);
    add_vec(0,  0, 32'h0,        1,  4, 0, 4, 32'h0,        0, 1); // alloc x4
    add_vec(1,  4, 32'hAA,       1,  4, 0, 4, 32'hAA,       1, 1); // wr+alloc
    add_vec(0,  0, 32'h0,        0,  0, 0, 4, 32'hAA,       1, 1);
    add_vec(0,  0, 32'h0,        1,  1, 0, 1, 32'h0,        0, 2);
    add_vec(0,  0, 32'h0,        1,  2, 0, 2, 32'h0,        0, 3);
    add_vec(0,  0, 32'h0,        1,  6, 0, 6, 32'h0,        0, 4);
    add_vec(0,  0, 32'h0,        1,  7, 1, 7, 32'h0,        0, 0); // flush wins
    add_vec(0,  0, 32'h0,        0,  0, 0, 4, 32'hAA,       0, 0);
    add_vec(0,  0, 32'h0,        1,  0, 0, 0, 32'h0,        0, 0); // alloc x0
    add_vec(0,  0, 32'h0,        1,  3, 0, 3, 32'h7,        0, 1);
    add_vec(0,  0, 32'h0,        1,  3, 0, 3, 32'h7,        1, 1); // re-alloc
    add_vec(1,  3, 32'h9,        0,  0, 1, 3, 32'h9,        0, 0); // wr+flush

    // Reset state: everything reads zero, even with a write pending.
    #2;
    wr_en = 1'b1; wr_addr = AW'(5); wr_data = 32'hFFFF_FFFF;
    set_rd(0, 5);
    #1;
    check("reset bypass gated", 64'(rs_data[0 +: XLEN]), 64'h0);
    check("reset busy_cnt", 64'(busy_cnt), 64'h0);
    drive_idle();
    for (int a = 1; a < NREG; a++) begin
      for (int k = 0; k < NRD; k++) set_rd(k, a);
      #1;
      check_ports("reset");
    end
    wr_en = 1'b1; wr_addr = AW'(5); wr_data = 32'hFFFF_FFFF;
    alloc_en = 1'b1; alloc_addr = AW'(6);
    clock_edge("reset edge");
    rst = 1'b0;
    drive_idle();

    // Directed table.
    for (int i = 0; i < nvec; i++) begin
      wr_en = vt[i].we; wr_addr = AW'(vt[i].wa); wr_data = vt[i].wd;
      alloc_en = vt[i].ae; alloc_addr = AW'(vt[i].aa); flush = vt[i].fl;
      set_rd(0, vt[i].ra);
      set_rd(NRD - 1, $urandom_range(0, NREG - 1));
      #2;
      check($sformatf("vec%0d data", i), 64'(rs_data[0 +: XLEN]), 64'(vt[i].exp_data));
      check($sformatf("vec%0d busy", i), 64'(rs_busy[0]), 64'(vt[i].exp_busy));
      check_ports($sformatf("vec%0d", i));
      @(posedge clk);
      model_edge();
      #1;
      check($sformatf("vec%0d cnt", i), 64'(busy_cnt), 64'(vt[i].exp_cnt));
      drive_idle();
    end

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      wr_en = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom_range(0, NREG - 1));
      wr_data = XLEN'($urandom);
      alloc_en = 1'($urandom_range(0, 1));
      alloc_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, NREG - 1));
      flush = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < NRD; k++) begin
        set_rd(k, ($urandom_range(0, 2) == 0) ? int'(wr_addr) : int'($urandom_range(0, NREG - 1)));
      end
      #2;
      check_ports("rand");
      clock_edge("rand");
    end
    drive_idle();

    // Asynchronous reset with a live reservation.
    wr_en = 1'b1; wr_addr = AW'(9); wr_data = 32'h55;
    alloc_en = 1'b1; alloc_addr = AW'(9); flush = 1'b0;
    clock_edge("pre-rst");
    drive_idle();
    set_rd(0, 9);
    #2;
    check("pre-rst data x9", 64'(rs_data[0 +: XLEN]), 64'h55);
    check("pre-rst busy x9", 64'(rs_busy[0]), 64'h1);
    rst = 1'b1;
    model_reset();
    wr_en = 1'b1; wr_addr = AW'(9); wr_data = 32'h77;
    #1;
    check("async rst busy_cnt", 64'(busy_cnt), 64'h0);
    check("async rst data x9", 64'(rs_data[0 +: XLEN]), 64'h0);
    check("async rst busy x9", 64'(rs_busy[0]), 64'h0);
    clock_edge("in-rst");
    rst = 1'b0;
    drive_idle();
    #2;
    check("post-rst data x9", 64'(rs_data[0 +: XLEN]), 64'h0);
    wr_en = 1'b1; wr_addr = AW'(9); wr_data = 32'h66;
    alloc_en = 1'b1; alloc_addr = AW'(2);
    #1;
    check_ports("post-rst");
    clock_edge("post-rst");
    drive_idle();
    #2;
    check_ports("post-rst hold");
    check("post-rst stored x9", 64'(rs_data[0 +: XLEN]), 64'h66);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
